maze_game: RTL and testbench
============================

// Module: maze_game
// PURPOSE
//  Top-level maze game core: generates a random perfect maze (recursive backtracker),
//  exposes it as a 1-bit wall bitmap, moves a player on the cell grid from one-hot
//  direction pulses, and on reaching the exit counts the maze and regenerates.
//  Sits between the input debouncer/timer logic and the display renderer.
// PARAMETERS
//  WIDTH   15  maze width in cells (>=2); bitmap width MW = 2*WIDTH+1
//  HEIGHT  15  maze height in cells (>=2); bitmap height MH = 2*HEIGHT+1; MW*MH <= 2048
// PORTS
//  clock              in   1   system clock, all logic on rising edge
//  reset              in   1   asynchronous, active-low reset
//  maze_address       in   11  bitmap address = row*MW + col
//  maze_address_data  out  1   bitmap bit at maze_address: 1 = wall, 0 = path (combinational)
//  player_direction   in   4   one-hot move: [3]=up [2]=right [1]=down [0]=left
//  timer_end          in   1   1 = game time over, freeze player
//  player_x           out  8   player cell column, 0..WIDTH-1
//  player_y           out  8   player cell row, 0..HEIGHT-1
//  gen_end            out  1   1 = maze generated, play active
//  mazes_complete     out  8   count of exits reached, wraps 255->0
// BEHAVIOUR
//  - Reset: player_x=0, player_y=0, gen_end=0, mazes_complete=0, FSM->CLEAR; 16-bit LFSR
//    (x^16+x^14+x^13+x^11+1) = 16'hACE1. LFSR steps every clock, never reset otherwise.
//  - Cell (x,y) centre at bitmap (col=2x+1,row=2y+1); passage between adjacent cells is the
//    bitmap bit midway between them. maze_address >= MW*MH reads 1.
//  - FSM: CLEAR (one bitmap bit per cycle set to 1, visited bits cleared) -> INIT (push cell
//    (0,0), mark visited, clear its centre) -> CARVE: collect unvisited neighbours of top of
//    stack; none -> BACKTRACK (pop; stack empty -> DONE); else pick LFSR[1:0] mod count,
//    clear passage+centre, mark visited, push -> CARVE. Stack depth WIDTH*HEIGHT.
//    DONE -> PLAY: gen_end=1. Generation completes within MW*MH + 4*WIDTH*HEIGHT + 8 cycles.
//  - Bitmap readable at all times; during generation it reflects partial state.
//  - Movement only in PLAY with timer_end=0: on the cycle player_direction changes from
//    4'b0000 to a one-hot value, move one cell if target is in-grid and the passage bit is 0.
//    Held direction moves once only; must return to 0 before next move. Non-one-hot ignored.
//    Walls and grid edges block with no state change.
//  - Exit = cell (WIDTH-1,HEIGHT-1). Player update into exit: next cycle gen_end=0,
//    mazes_complete+1, player -> (0,0), FSM -> CLEAR (new maze from current LFSR).
//  - timer_end=1: no moves, no completion; generation (if running) continues.
//  - Direction input during generation is ignored; edge detector register still tracks it.
//  - Reset mid-generation or mid-play: abort immediately, restart at CLEAR after release.
// TESTING
//  1. Reset low 2 cycles, release, WIDTH=5 HEIGHT=2 -> gen_end=0 then 1 within 85 cycles;
//     player (0,0), mazes_complete 0.
//  2. Read addresses 0..54 -> border all 1, all 10 cell centres 0, exactly 9 inter-cell
//     passages 0, maze connected (perfect maze); address 60 reads 1.
//  3. Solve by BFS over bitmap; per step drive one-hot dir 4 cycles, 0 for 1 cycle -> one cell
//     per pulse; on entering (4,1) gen_end=0 within 2 cycles, mazes_complete=1, player (0,0).
//  4. At (0,0) drive 4'b0001 and 4'b1000 (off-grid), 4'b0110 (multi-bit), and a walled
//     direction -> player stays (0,0).
//  5. After regeneration set timer_end=1, drive 4'b0100 for 5 cycles -> player stays (0,0),
//     gen_end stays 1.
//  6. Assert reset mid-generation and mid-play -> all outputs at reset values asynchronously;
//     after release generation restarts and gen_end rises again.

Source files
------------

// File: rtl/maze_game.sv
// Maze game core: builds a random perfect maze with a recursive backtracker,
// serves it as a wall bitmap and walks a player through it until the exit is reached.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_CLEAR | fill bitmap with walls one bit per cycle, forget visited cells
// S_INIT  | push cell (0,0), mark it visited, open its centre
// S_CARVE | carve to a random unvisited neighbour of the stack top, or pop on
//         | a dead end (backtrack); popping the last entry ends generation
// S_DONE  | raise gen_end
// S_PLAY  | move player on direction edges, regenerate on reaching the exit
module maze_game #(
  parameter int WIDTH  = 15,
  parameter int HEIGHT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] maze_address,
  output logic        maze_address_data,
  input  logic [3:0]  player_direction,
  input  logic        timer_end,
  output logic [7:0]  player_x,
  output logic [7:0]  player_y,
  output logic        gen_end,
  output logic [7:0]  mazes_complete
);
  localparam int MW = 2 * WIDTH + 1;
  localparam int MH = 2 * HEIGHT + 1;
  localparam int NB = MW * MH;
  localparam int AW = $clog2(NB);
  localparam int NC = WIDTH * HEIGHT;
  localparam int CW = $clog2(NC);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  typedef enum logic [2:0] {S_CLEAR, S_INIT, S_CARVE, S_DONE, S_PLAY} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [NB-1:0] bitmap;
  logic [NC-1:0] visited;
  logic [AW-1:0] clr_cnt;
  logic [CW-1:0] tp;
  logic [3:0]    dir_q;
  logic [XW-1:0] stack_x [NC];
  logic [YW-1:0] stack_y [NC];

  function automatic int centre(input int x, input int y);
    return (2 * y + 1) * MW + 2 * x + 1;
  endfunction

  function automatic logic [CW-1:0] cidx(input int x, input int y);
    return CW'(y * WIDTH + x);
  endfunction

  assign maze_address_data = (int'(maze_address) < NB) ? bitmap[maze_address[AW-1:0]] : 1'b1;

  // Neighbour selection for the cell on top of the stack; nbr bit order matches player_direction.
  int            tx, ty, n_cnt, n_sel, n_k, pick, dx, dy;
  logic [3:0]    nbr;
  logic [AW-1:0] pass_a, newc_a;
  logic [XW-1:0] new_x;
  logic [YW-1:0] new_y;
  logic [CW-1:0] new_i;

  always_comb begin
    tx = int'(stack_x[tp]);
    ty = int'(stack_y[tp]);
    nbr = 4'b0000;
    nbr[3] = (ty > 0)          && !visited[cidx(tx, ty - 1)];
    nbr[2] = (tx < WIDTH - 1)  && !visited[cidx(tx + 1, ty)];
    nbr[1] = (ty < HEIGHT - 1) && !visited[cidx(tx, ty + 1)];
    nbr[0] = (tx > 0)          && !visited[cidx(tx - 1, ty)];
    n_cnt = 0;
    for (int i = 0; i < 4; i++) if (nbr[i]) n_cnt++;
    n_sel = (n_cnt == 0) ? 0 : int'(lfsr[1:0]) % n_cnt;
    n_k = 0;
    pick = 0;
    for (int i = 0; i < 4; i++) begin
      if (nbr[i]) begin
        if (n_k == n_sel) pick = i;
        n_k++;
      end
    end
    dx = 0;
    dy = 0;
    case (pick)
      3:       dy = -1;
      2:       dx = 1;
      1:       dy = 1;
      default: dx = -1;
    endcase
    pass_a = AW'(centre(tx, ty) + dy * MW + dx);
    newc_a = AW'(centre(tx + dx, ty + dy));
    new_x  = XW'(tx + dx);
    new_y  = YW'(ty + dy);
    new_i  = cidx(tx + dx, ty + dy);
  end

  int         px, py, mdx, mdy;
  logic       mv_ok, move_fire;
  logic [7:0] mv_x, mv_y;

  always_comb begin
    px = int'(player_x);
    py = int'(player_y);
    mdx = 0;
    mdy = 0;
    case (player_direction)
      4'b1000: if (py > 0)          mdy = -1;
      4'b0100: if (px < WIDTH - 1)  mdx = 1;
      4'b0010: if (py < HEIGHT - 1) mdy = 1;
      4'b0001: if (px > 0)          mdx = -1;
      default: ;
    endcase
    mv_ok = ((mdx != 0) || (mdy != 0)) && !bitmap[AW'(centre(px, py) + mdy * MW + mdx)];
    mv_x = 8'(px + mdx);
    mv_y = 8'(py + mdy);
    move_fire = (state == S_PLAY) && !timer_end && (dir_q == 4'b0000) && mv_ok;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_CLEAR;
      lfsr           <= 16'hACE1;
      bitmap         <= '1;
      visited        <= '0;
      clr_cnt        <= AW'(NB - 1);
      tp             <= '0;
      dir_q          <= 4'b0000;
      player_x       <= 8'd0;
      player_y       <= 8'd0;
      gen_end        <= 1'b0;
      mazes_complete <= 8'd0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      dir_q <= player_direction;
      case (state)
        S_CLEAR: begin
          bitmap[clr_cnt] <= 1'b1;
          visited <= '0;
          if (clr_cnt == '0) state <= S_INIT;
          else clr_cnt <= clr_cnt - AW'(1);
        end
        S_INIT: begin
          visited[0] <= 1'b1;
          bitmap[AW'(MW + 1)] <= 1'b0;
          tp <= '0;
          clr_cnt <= AW'(NB - 1);
          state <= S_CARVE;
        end
        S_CARVE: begin
          if (nbr != 4'b0000) begin
            bitmap[pass_a] <= 1'b0;
            bitmap[newc_a] <= 1'b0;
            visited[new_i] <= 1'b1;
            tp <= tp + CW'(1);
          end else if (tp == '0) begin
            state <= S_DONE;
          end else begin
            tp <= tp - CW'(1);
          end
        end
        S_DONE: begin
          gen_end <= 1'b1;
          state <= S_PLAY;
        end
        S_PLAY: begin
          if (!timer_end) begin
            if (player_x == 8'(WIDTH - 1) && player_y == 8'(HEIGHT - 1)) begin
              gen_end        <= 1'b0;
              mazes_complete <= mazes_complete + 8'd1;
              player_x       <= 8'd0;
              player_y       <= 8'd0;
              state          <= S_CLEAR;
            end else if (move_fire) begin
              player_x <= mv_x;
              player_y <= mv_y;
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Stack entries are plain storage; entry 0 is always the start cell.
  always_ff @(posedge clock) begin
    if (state == S_INIT) begin
      stack_x[0] <= '0;
      stack_y[0] <= '0;
    end else if (state == S_CARVE && nbr != 4'b0000) begin
      stack_x[tp + CW'(1)] <= new_x;
      stack_y[tp + CW'(1)] <= new_y;
    end
  end

endmodule

// File: tb/tb_maze_game.sv
// Directed bench for maze_game on a 5x2 maze: generation, bitmap structure,
// solving via BFS, blocked moves, timer freeze and asynchronous reset.
module tb_maze_game;
  localparam int W  = 5;
  localparam int H  = 2;
  localparam int MW = 2 * W + 1;
  localparam int NB = MW * (2 * H + 1);

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] maze_address;
  logic        maze_address_data;
  logic [3:0]  player_direction;
  logic        timer_end;
  logic [7:0]  player_x, player_y, mazes_complete;
  logic        gen_end;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic mz [NB];
  int   path [$];

  maze_game #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .maze_address(maze_address),
    .maze_address_data(maze_address_data), .player_direction(player_direction),
    .timer_end(timer_end), .player_x(player_x), .player_y(player_y),
    .gen_end(gen_end), .mazes_complete(mazes_complete)
  );

  always #5 clock = ~clock;

  function automatic int cen(input int x, input int y);
    return (2 * y + 1) * MW + 2 * x + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_gen(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit && gen_end !== 1'b1) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic read_maze();
    for (int a = 0; a < NB; a++) begin
      maze_address = 11'(a);
      #1;
      mz[a] = maze_address_data;
    end
    tick(1);
  endtask

  task automatic solve_bfs(output int reached);
    int prev [W*H];
    int q [$];
    int dxs [4] = '{-1, 0, 1, 0};
    int dys [4] = '{0, 1, 0, -1};
    int c, x, y, nx, ny, n;
    for (int i = 0; i < W * H; i++) prev[i] = -2;
    prev[0] = -1;
    q.push_back(0);
    reached = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      reached++;
      x = c % W;
      y = c / W;
      for (int d = 0; d < 4; d++) begin
        nx = x + dxs[d];
        ny = y + dys[d];
        if (nx >= 0 && nx < W && ny >= 0 && ny < H && !mz[cen(x, y) + dys[d] * MW + dxs[d]]) begin
          n = ny * W + nx;
          if (prev[n] == -2) begin
            prev[n] = c;
            q.push_back(n);
          end
        end
      end
    end
    path.delete();
    c = W * H - 1;
    while (c > 0 && prev[c] >= 0) begin
      path.push_front(c);
      c = prev[c];
    end
  endtask

  function automatic logic [3:0] dir_of(input int dx, input int dy);
    if (dy < 0) return 4'b1000;
    if (dx > 0) return 4'b0100;
    if (dy > 0) return 4'b0010;
    return 4'b0001;
  endfunction

  task automatic test_reset();
    int cyc;
    reset = 1'b0;
    player_direction = 4'b0000;
    timer_end = 1'b0;
    maze_address = 11'd0;
    tick(2);
    n_cmp++;
    if ({player_x, player_y, gen_end, mazes_complete} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_values: x=%0d y=%0d gen_end=%b mazes=%0d, want all 0", player_x, player_y, gen_end, mazes_complete);
    end
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if (gen_end !== 1'b0) begin
      n_bad++;
      $display("FAIL gen_early: gen_end=%b, want 0", gen_end);
    end
    wait_gen(85, cyc);
    n_cmp++;
    if (gen_end !== 1'b1) begin
      n_bad++;
      $display("FAIL gen_time: gen_end=%b after %0d cycles, want 1 within 85", gen_end, cyc);
    end
    n_cmp++;
    if (player_x !== 8'd0 || player_y !== 8'd0 || mazes_complete !== 8'd0) begin
      n_bad++;
      $display("FAIL post_gen_state: x=%0d y=%0d mazes=%0d, want 0 0 0", player_x, player_y, mazes_complete);
    end
  endtask

  task automatic test_bitmap();
    int bad_border, bad_post, bad_centre, open_pass, reached;
    read_maze();
    bad_border = 0;
    bad_post = 0;
    bad_centre = 0;
    open_pass = 0;
    for (int c = 0; c < MW; c++) begin
      if (!mz[c]) bad_border++;
      if (!mz[2 * H * MW + c]) bad_border++;
    end
    for (int r = 0; r <= 2 * H; r++) begin
      if (!mz[r * MW]) bad_border++;
      if (!mz[r * MW + MW - 1]) bad_border++;
    end
    for (int r = 0; r <= 2 * H; r += 2)
      for (int c = 0; c < MW; c += 2)
        if (!mz[r * MW + c]) bad_post++;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (mz[cen(x, y)]) bad_centre++;
        if (x < W - 1 && !mz[cen(x, y) + 1]) open_pass++;
        if (y < H - 1 && !mz[cen(x, y) + MW]) open_pass++;
      end
    n_cmp++;
    if (bad_border !== 0) begin
      n_bad++;
      $display("FAIL border: %0d open border bits, want 0", bad_border);
    end
    n_cmp++;
    if (bad_post !== 0) begin
      n_bad++;
      $display("FAIL posts: %0d open corner posts, want 0", bad_post);
    end
    n_cmp++;
    if (bad_centre !== 0) begin
      n_bad++;
      $display("FAIL centres: %0d walled centres, want 0", bad_centre);
    end
    n_cmp++;
    if (open_pass !== W * H - 1) begin
      n_bad++;
      $display("FAIL passages: %0d open, want %0d", open_pass, W * H - 1);
    end
    solve_bfs(reached);
    n_cmp++;
    if (reached !== W * H) begin
      n_bad++;
      $display("FAIL connected: reached %0d cells, want %0d", reached, W * H);
    end
    maze_address = 11'd60;
    #1;
    n_cmp++;
    if (maze_address_data !== 1'b1) begin
      n_bad++;
      $display("FAIL addr60: read %b, want 1", maze_address_data);
    end
    maze_address = 11'd2047;
    #1;
    n_cmp++;
    if (maze_address_data !== 1'b1) begin
      n_bad++;
      $display("FAIL addr2047: read %b, want 1", maze_address_data);
    end
    tick(1);
  endtask

  task automatic test_solve();
    int cx, cy, tx, ty, k;
    cx = 0;
    cy = 0;
    for (int i = 0; i < path.size(); i++) begin
      tx = path[i] % W;
      ty = path[i] / W;
      player_direction = dir_of(tx - cx, ty - cy);
      tick(1);
      n_cmp++;
      if (player_x !== 8'(tx) || player_y !== 8'(ty)) begin
        n_bad++;
        $display("FAIL step%0d: player (%0d,%0d), want (%0d,%0d)", i, player_x, player_y, tx, ty);
      end
      if (i < path.size() - 1) begin
        tick(3);
        n_cmp++;
        if (player_x !== 8'(tx) || player_y !== 8'(ty)) begin
          n_bad++;
          $display("FAIL hold%0d: player (%0d,%0d), want (%0d,%0d)", i, player_x, player_y, tx, ty);
        end
        player_direction = 4'b0000;
        tick(1);
      end
      cx = tx;
      cy = ty;
    end
    k = 0;
    while (k < 2 && gen_end !== 1'b0) begin
      tick(1);
      k++;
    end
    player_direction = 4'b0000;
    n_cmp++;
    if (gen_end !== 1'b0 || mazes_complete !== 8'd1) begin
      n_bad++;
      $display("FAIL exit: gen_end=%b mazes=%0d, want 0 and 1", gen_end, mazes_complete);
    end
    n_cmp++;
    if (player_x !== 8'd0 || player_y !== 8'd0) begin
      n_bad++;
      $display("FAIL exit_home: player (%0d,%0d), want (0,0)", player_x, player_y);
    end
  endtask

  task automatic test_blocked();
    int cyc;
    logic [3:0] vec [4];
    int nvec;
    tick(1);
    wait_gen(110, cyc);
    n_cmp++;
    if (gen_end !== 1'b1) begin
      n_bad++;
      $display("FAIL regen: gen_end=%b after %0d cycles, want 1", gen_end, cyc);
    end
    read_maze();
    vec[0] = 4'b0001;
    vec[1] = 4'b1000;
    vec[2] = 4'b0110;
    nvec = 3;
    if (mz[cen(0, 0) + 1]) begin
      vec[3] = 4'b0100;
      nvec = 4;
    end else if (mz[cen(0, 0) + MW]) begin
      vec[3] = 4'b0010;
      nvec = 4;
    end
    for (int i = 0; i < nvec; i++) begin
      player_direction = vec[i];
      tick(2);
      n_cmp++;
      if (player_x !== 8'd0 || player_y !== 8'd0 || gen_end !== 1'b1) begin
        n_bad++;
        $display("FAIL blocked_%b: player (%0d,%0d) gen_end=%b, want (0,0) 1", vec[i], player_x, player_y, gen_end);
      end
      player_direction = 4'b0000;
      tick(1);
    end
  endtask

  task automatic test_timer();
    logic [3:0] open_dir;
    int ex, ey;
    timer_end = 1'b1;
    player_direction = 4'b0100;
    tick(5);
    n_cmp++;
    if (player_x !== 8'd0 || player_y !== 8'd0 || gen_end !== 1'b1) begin
      n_bad++;
      $display("FAIL timer_freeze: player (%0d,%0d) gen_end=%b, want (0,0) 1", player_x, player_y, gen_end);
    end
    player_direction = 4'b0000;
    tick(1);
    timer_end = 1'b0;
    tick(1);
    open_dir = mz[cen(0, 0) + 1] ? 4'b0010 : 4'b0100;
    ex = (open_dir == 4'b0100) ? 1 : 0;
    ey = (open_dir == 4'b0010) ? 1 : 0;
    player_direction = open_dir;
    tick(1);
    n_cmp++;
    if (player_x !== 8'(ex) || player_y !== 8'(ey)) begin
      n_bad++;
      $display("FAIL timer_release: player (%0d,%0d), want (%0d,%0d)", player_x, player_y, ex, ey);
    end
    player_direction = 4'b0000;
    tick(1);
  endtask

  task automatic test_reset_mid();
    int cyc;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({player_x, player_y, gen_end, mazes_complete} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_play: x=%0d y=%0d gen_end=%b mazes=%0d, want all 0", player_x, player_y, gen_end, mazes_complete);
    end
    tick(2);
    reset = 1'b1;
    player_direction = 4'b0100;
    tick(30);
    n_cmp++;
    if (gen_end !== 1'b0) begin
      n_bad++;
      $display("FAIL midgen_busy: gen_end=%b, want 0", gen_end);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (gen_end !== 1'b0 || player_x !== 8'd0 || player_y !== 8'd0 || mazes_complete !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_gen: x=%0d y=%0d gen_end=%b mazes=%0d, want all 0", player_x, player_y, gen_end, mazes_complete);
    end
    tick(2);
    reset = 1'b1;
    tick(1);
    wait_gen(85, cyc);
    n_cmp++;
    if (gen_end !== 1'b1) begin
      n_bad++;
      $display("FAIL regen_after_reset: gen_end=%b after %0d cycles, want 1", gen_end, cyc);
    end
    tick(3);
    n_cmp++;
    if (player_x !== 8'd0 || player_y !== 8'd0) begin
      n_bad++;
      $display("FAIL held_through_gen: player (%0d,%0d), want (0,0)", player_x, player_y);
    end
    player_direction = 4'b0000;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_bitmap();
    test_solve();
    test_blocked();
    test_timer();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
